// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - execute-stage ALU with iterative MULTU/DIVU and HI/LO registers
module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [3:0]       alucontrol,
    input  logic             start,
    output logic [WIDTH-1:0] aluresult,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;
    localparam logic [3:0] OP_SLTU  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    logic             is_div;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] opb;
    logic [CW-1:0]    count;

    logic             launch;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [WIDTH-1:0] nxt_acc;
    logic [WIDTH-1:0] nxt_quo;
    logic             slt_bit;

    assign launch = start && (state != S_RUN)
                    && (alucontrol == OP_MULTU || alucontrol == OP_DIVU);

    // acc holds the running high half (multiply) or partial remainder (divide);
    // quo holds the multiplier being shifted out, or the dividend/quotient.
    always_comb begin
        mul_sum   = {1'b0, acc} + (quo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = {acc, quo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb};
        nxt_acc   = '0;
        nxt_quo   = '0;
        if (is_div) begin
            if (div_diff[WIDTH+1]) begin
                nxt_acc = div_shift[WIDTH-1:0];
                nxt_quo = {quo[WIDTH-2:0], 1'b0};
            end else begin
                nxt_acc = div_diff[WIDTH-1:0];
                nxt_quo = {quo[WIDTH-2:0], 1'b1};
            end
        end else begin
            nxt_acc = mul_sum[WIDTH:1];
            nxt_quo = {mul_sum[0], quo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
            acc    <= '0;
            quo    <= '0;
            opb    <= '0;
            is_div <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (launch) begin
                        state  <= S_RUN;
                        busy   <= 1'b1;
                        acc    <= '0;
                        quo    <= srca;
                        opb    <= srcb;
                        count  <= '0;
                        is_div <= (alucontrol == OP_DIVU);
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc   <= nxt_acc;
                    quo   <= nxt_quo;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        hi    <= nxt_acc;
                        lo    <= nxt_quo;
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign slt_bit = ($signed(srca) < $signed(srcb));

    always_comb begin
        aluresult = '0;
        case (alucontrol)
            OP_AND:  aluresult = srca & srcb;
            OP_OR:   aluresult = srca | srcb;
            OP_ADD:  aluresult = srca + srcb;
            OP_XOR:  aluresult = srca ^ srcb;
            OP_NOR:  aluresult = ~(srca | srcb);
            OP_SUB:  aluresult = srca - srcb;
            OP_SLT:  aluresult = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_SLTU: aluresult = {{(WIDTH-1){1'b0}}, (srca < srcb)};
            OP_MFHI: aluresult = hi;
            OP_MFLO: aluresult = lo;
            default: aluresult = '0;
        endcase
    end

    assign zero = (aluresult == '0);
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - scoreboard bench for alu_mdu at WIDTH=8
module tb_alu_mdu;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] srca, srcb;
    logic [3:0]   alucontrol;
    logic         start;
    logic [W-1:0] aluresult;
    logic         zero, busy, done;
    logic [W-1:0] hi, lo;

    alu_mdu #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .srca(srca), .srcb(srcb),
        .alucontrol(alucontrol), .start(start), .aluresult(aluresult),
        .zero(zero), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t         sbq[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           launch_cyc = 0;
    bit           launched = 0;
    bit           mon_en = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    endtask

    function automatic logic [W-1:0] cur_hi();
        if (sbq.size() > 0 && cyc >= sbq[0].cyc) return sbq[0].hi;
        return model_hi;
    endfunction

    function automatic logic [W-1:0] cur_lo();
        if (sbq.size() > 0 && cyc >= sbq[0].cyc) return sbq[0].lo;
        return model_lo;
    endfunction

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int ia, ib, sa, sb;
        ia = int'(a);
        ib = int'(b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return W'((ia + ib) % 256);
            4'd3:  return a ^ b;
            4'd4:  return W'(255 - (ia | ib));
            4'd6:  return W'((ia - ib + 256) % 256);
            4'd7:  return (sa < sb) ? W'(1) : W'(0);
            4'd15: return (ia < ib) ? W'(1) : W'(0);
            4'd10: return cur_hi();
            4'd11: return cur_lo();
            default: return '0;
        endcase
    endfunction

    function automatic exp_t ref_mdu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   p;
        if (op == 4'd8) begin
            p    = int'(a) * int'(b);
            e.hi = W'(p / 256);
            e.lo = W'(p % 256);
        end else if (b == 0) begin
            e.hi = a;
            e.lo = 8'hFF;
        end else begin
            e.hi = W'(int'(a) % int'(b));
            e.lo = W'(int'(a) / int'(b));
        end
        e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_done;
            exp_done = (sbq.size() > 0 && sbq[0].cyc == cyc);
            chk("done", done, exp_done);
            chk("busy", busy, launched && cyc >= launch_cyc && cyc <= launch_cyc + W - 1);
            if (exp_done) begin
                model_hi = sbq[0].hi;
                model_lo = sbq[0].lo;
                void'(sbq.pop_front());
            end
            chk("hi", hi, model_hi);
            chk("lo", lo, model_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit st);
        logic [W-1:0] e;
        alucontrol = op;
        srca       = a;
        srcb       = b;
        start      = st;
        #1;
        e = ref_alu(op, a, b);
        chk("aluresult", aluresult, e);
        chk("zero", zero, e == 0);
    endtask

    task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        alu(op, a, b, 1'b1);
        e     = ref_mdu(op, a, b);
        e.cyc = cyc + 1 + W;
        sbq.push_back(e);
        launch_cyc = cyc + 1;
        launched   = 1;
        tick();
        start = 1'b0;
        srca  = W'($urandom);
        srcb  = W'($urandom);
    endtask

    task automatic run_noise(input bit allow_start);
        for (int i = 0; i < W; i++) begin
            alu(4'(8 + ($urandom % 4)), W'($urandom), W'($urandom), allow_start && ($urandom % 2 == 1));
            tick();
        end
        start = 1'b0;
    endtask

    task automatic clear_model();
        sbq.delete();
        launched = 0;
        model_hi = '0;
        model_lo = '0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; srca = '0; srcb = '0; alucontrol = '0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        reset  = 1'b0;
        mon_en = 1;

        alu(4'b0110, 8'h05, 8'h05, 0); chk("sub_5_5", aluresult, 8'h00); chk("sub_zero", zero, 1); tick();
        alu(4'b0010, 8'hFF, 8'h01, 0); chk("add_wrap", aluresult, 8'h00); chk("add_zero", zero, 1); tick();
        alu(4'b0111, 8'hFF, 8'h01, 0); chk("slt_neg", aluresult, 8'h01); tick();
        alu(4'b1111, 8'hFF, 8'h01, 0); chk("sltu", aluresult, 8'h00); tick();
        alu(4'b0100, 8'h0F, 8'hF0, 0); chk("nor", aluresult, 8'h00); tick();

        launch(4'b1000, 8'd200, 8'd3);
        for (int i = 0; i < W; i++) begin
            alu(4'b1011, 8'h00, 8'h00, 0); tick();
        end
        chk("mul_done", done, 1);
        alu(4'b1011, 8'h00, 8'h00, 0); chk("mflo_mul", aluresult, 8'h58); tick();
        alu(4'b1010, 8'h00, 8'h00, 0); chk("mfhi_mul", aluresult, 8'h02); tick();

        launch(4'b1001, 8'd100, 8'd7);
        run_noise(1);
        alu(4'b1011, 8'h00, 8'h00, 0); chk("divu_q", aluresult, 8'h0E);
        alu(4'b1010, 8'h00, 8'h00, 0); chk("divu_r", aluresult, 8'h02);
        launch(4'b1001, 8'd45, 8'd0);
        chk("b2b_busy", busy, 1);
        run_noise(1);
        alu(4'b1011, 8'h00, 8'h00, 0); chk("div0_q", aluresult, 8'hFF);
        alu(4'b1010, 8'h00, 8'h00, 0); chk("div0_r", aluresult, 8'h2D);
        tick();

        launch(4'b1000, 8'd17, 8'd9);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        chk("abort_busy", busy, 0);
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        repeat (W + 2) tick();

        alucontrol = 4'b1000; start = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; start = 1'b0;
        chk("reset_wins", busy, 0);
        tick();

        launch(4'b1000, 8'd200, 8'd3);
        repeat (W) tick();
        alu(4'b1011, 8'h00, 8'h00, 0); chk("fresh_mflo", aluresult, 8'h58);
        tick();

        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom % 6 == 0) ? W'(0) : W'($urandom);
            launch(($urandom % 2 == 1) ? 4'b1001 : 4'b1000, a, b);
            for (int i = 0; i < W; i++) begin
                alu(4'($urandom), W'($urandom), W'($urandom), $urandom % 2 == 1);
                tick();
            end
            start = 1'b0;
            if ($urandom % 2 == 1) begin
                alu(4'($urandom % 8), W'($urandom), W'($urandom), 0);
                tick();
            end
        end

        repeat (W + 2) tick();
        chk("sb_drain", 16'(sbq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised ALU with an attached iterative multiply/divide unit and HI/LO result registers, for the MIPS datapath's execute stage. Single-cycle ops (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, MFHI, MFLO) are combinational from the operands. MULTU and DIVU run for WIDTH cycles under a start/busy/done handshake, and the controller stalls on `busy`. `zero` is derived from the actual result.

## Interface
- WIDTH, 32: operand, result, HI and LO width; must be at least 4.
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- srca  in  WIDTH  operand A (dividend for DIVU)
- srcb  in  WIDTH  operand B (divisor for DIVU)
- alucontrol  in  4  operation select (codes below)
- start  in  1  launch MULTU/DIVU; sampled together with alucontrol
- aluresult  out  WIDTH  combinational result of the single-cycle op
- zero  out  1  high when aluresult == 0
- busy  out  1  multi-cycle op in progress
- done  out  1  one-cycle pulse; HI/LO hold the new result
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

## Operation
- Codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR
  - 0110 SUB (srca − srcb, two's complement, wraps mod 2^WIDTH)
  - 0111 SLT (signed compare, result 1 or 0, zero-extended)
  - 1111 SLTU (unsigned compare)
  - 1000 MULTU; 1001 DIVU; 1010 MFHI (aluresult = hi); 1011 MFLO (aluresult = lo)
  - All other codes: aluresult = 0.
- ADD/SUB: no overflow flag; carry-out is discarded.
- MULTU/DIVU have aluresult = 0. Their only effect is through start, HI and LO.
- Single-cycle ops stay fully functional while busy. MFHI/MFLO return the current (old) HI/LO until done.
- FSM states:
  - IDLE → RUN on start=1 with alucontrol ∈ {MULTU, DIVU}. Operands, the op, and the iteration counter (cleared to 0) are captured.
  - RUN performs one iteration per cycle. After WIDTH iterations, HI/LO are written and the FSM moves to DONE.
  - DONE → RUN on a qualifying start (back-to-back launch); otherwise DONE → IDLE.
- start is ignored in RUN, and also with any other alucontrol value.
- MULTU uses unsigned shift-add producing a 2·WIDTH-bit product: hi = upper half, lo = lower half.
- DIVU uses unsigned restoring division: lo = quotient, hi = remainder.
- Divide by zero is not special-cased. It runs the full WIDTH iterations, giving lo = all ones and hi = srca (captured value).
- Operand changes after launch have no effect on the running op.

## Timing
- Reset values:
  - state = IDLE; busy = 0; done = 0; hi = 0; lo = 0; counter = 0.
  - aluresult and zero follow the inputs combinationally, with hi/lo = 0.
- Launch at edge k:
  - busy = 1 for cycles k+1 through k+WIDTH (WIDTH cycles).
  - HI/LO are updated at edge k+WIDTH.
  - done = 1 for exactly the cycle after edge k+WIDTH, with busy = 0 in that cycle.
- A back-to-back start sampled during the DONE cycle raises busy in the next cycle with no IDLE gap.
- HI/LO change only at the completion edge; there are no partial-result updates.
- Reset asserted in any state, including mid-RUN:
  - The next edge forces all reset values and aborts the op.
  - No done pulse is produced.
  - HI/LO are cleared to 0.
- reset and start in the same cycle: reset wins.
- Combinational path: srca/srcb/alucontrol/hi/lo → aluresult → zero. No registered latency on single-cycle ops.

## Test plan
- WIDTH=8; SUB 0x05 − 0x05 → aluresult 0x00, zero 1. ADD 0xFF + 0x01 → 0x00, zero 1 (wrap).
- SLT with srca=0xFF, srcb=0x01 → 0x01. SLTU with the same operands → 0x00. NOR 0x0F, 0xF0 → 0x00.
- MULTU 200 × 3 launched at edge k → busy for 8 cycles; done in the cycle after edge k+8; hi=0x02, lo=0x58. MFLO then → 0x58.
- DIVU 100 ÷ 7 → lo=0x0E, hi=0x02.
  - A second DIVU launched during done must set busy next cycle.
  - start pulses mid-RUN must be ignored.
- DIVU 45 ÷ 0 → after 8 cycles, lo=0xFF, hi=0x2D, done pulse.
- Launch MULTU, assert reset at cycle 4 → busy=0, done never pulses, hi=lo=0. A fresh MULTU then completes correctly.
